// File: rtl/parametric_register_file.sv
// parametric_register_file
//
// Register file with REGISTER_COUNT entries of DATA_WIDTH bits. It has two
// asynchronous read ports and one synchronous write port. Register 0 always
// reads as zero.
//
// A two-state clear engine (IDLE / CLEAR) walks registers 1..REGISTER_COUNT-1
// and zeroes one register per cycle. A write is rejected if it targets
// index 0 or arrives while a sweep is running. Each rejection produces a
// one-cycle pulse and advances a saturating 8-bit counter.
//
// Optional build macro: READ_BYPASS_EN
//   defined   - an accepted write is forwarded combinationally to any read
//               port addressing the same index in the same cycle
//   undefined - reads always return the stored array contents
//
// Ports
//   clock                  single clock, all state updates on posedge
//   reset                  synchronous, active-high; reloads register i with i
//   read_register_index_1  read port 1 index
//   read_register_index_2  read port 2 index
//   read_data_1            contents of register at read_register_index_1
//   read_data_2            contents of register at read_register_index_2
//   write_register_index   write target
//   write_data             write value
//   write_signal           write request for this cycle
//   clear_request          one-cycle request to zero all registers
//   clear_busy             high while the clear engine sweeps; this is the
//                          visible form of the FSM state (1 = CLEAR)
//   clear_done             one-cycle pulse after the final register is cleared
//   write_rejected         one-cycle pulse the cycle after a rejected write
//   rejected_write_count   saturating count of rejected writes
//
// Handshake: clear_request is sampled only in IDLE. The sweep starts on the
// next cycle with clear_busy=1. It ends with clear_busy=0 and clear_done=1
// for exactly one cycle. A request made while busy is dropped.
module parametric_register_file #(
  parameter int  DATA_WIDTH     = 32,
  parameter int  REGISTER_COUNT = 32,
  localparam int INDEX_WIDTH    = $clog2(REGISTER_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] read_register_index_1,
  input  logic [INDEX_WIDTH-1:0] read_register_index_2,
  output logic [DATA_WIDTH-1:0]  read_data_1,
  output logic [DATA_WIDTH-1:0]  read_data_2,
  input  logic [INDEX_WIDTH-1:0] write_register_index,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   write_signal,
  input  logic                   clear_request,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   write_rejected,
  output logic [7:0]             rejected_write_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(REGISTER_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] FIRST_INDEX = INDEX_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  regs_q [REGISTER_COUNT];
  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic                   clear_done_q, clear_done_d;
  logic                   write_rejected_q;
  logic [7:0]             reject_count_q;

  logic write_accept;
  logic write_reject;

  // Reset is folded in here so that the bypass path never forwards data
  // during a reset cycle. The array itself gets reset priority in the
  // always_ff block.
  assign write_accept = write_signal && !reset &&
                        (write_register_index != '0) && (state_q == ST_IDLE);
  assign write_reject = write_signal && !reset &&
                        ((write_register_index == '0) || (state_q == ST_CLEAR));

  // Next-state logic for the clear engine.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_request) begin
          state_d = ST_CLEAR;
          ptr_d   = FIRST_INDEX;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_INDEX) begin
          state_d      = ST_IDLE;
          ptr_d        = FIRST_INDEX;
          clear_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + FIRST_INDEX;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Entry i reloads with i truncated to DATA_WIDTH. Entry 0 therefore
      // loads 0.
      for (int i = 0; i < REGISTER_COUNT; i++) begin
        regs_q[i] <= DATA_WIDTH'(i);
      end
      state_q          <= ST_IDLE;
      ptr_q            <= FIRST_INDEX;
      clear_done_q     <= 1'b0;
      write_rejected_q <= 1'b0;
      reject_count_q   <= 8'd0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      clear_done_q     <= clear_done_d;
      write_rejected_q <= write_reject;
      if (write_reject && (reject_count_q != 8'hFF)) begin
        reject_count_q <= reject_count_q + 8'd1;
      end
      // Writes are only accepted in IDLE and the sweep only runs in CLEAR,
      // so these two updates never collide.
      if (write_accept) begin
        regs_q[write_register_index] <= write_data;
      end
      if (state_q == ST_CLEAR) begin
        regs_q[ptr_q] <= '0;
      end
    end
  end

  always_comb begin
    read_data_1 = (read_register_index_1 == '0) ? '0 : regs_q[read_register_index_1];
    read_data_2 = (read_register_index_2 == '0) ? '0 : regs_q[read_register_index_2];
`ifdef READ_BYPASS_EN
    // Same-cycle forwarding of an accepted write. write_accept already
    // excludes index 0, rejected writes and reset cycles.
    if (write_accept && (read_register_index_1 == write_register_index)) begin
      read_data_1 = write_data;
    end
    if (write_accept && (read_register_index_2 == write_register_index)) begin
      read_data_2 = write_data;
    end
`endif
  end

  assign clear_busy           = (state_q == ST_CLEAR);
  assign clear_done           = clear_done_q;
  assign write_rejected       = write_rejected_q;
  assign rejected_write_count = reject_count_q;

endmodule

// File: tb/tb_parametric_register_file.sv
// Directed testbench for parametric_register_file (32 x 32 default build).
// Expected values come from a small reference array and the timing rules of
// the clear engine. They are pushed onto exp_q when stimulus is driven and
// popped when the matching DUT output is sampled.
module tb_parametric_register_file;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int IW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] rd_idx_1 = '0;
  logic [IW-1:0] rd_idx_2 = '0;
  logic [DW-1:0] rd_data_1;
  logic [DW-1:0] rd_data_2;
  logic [IW-1:0] wr_idx = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_sig = 1'b0;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_rej;
  logic [7:0]    rej_cnt;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [RC];
  int checks = 0;
  int errors = 0;

  parametric_register_file #(.DATA_WIDTH(DW), .REGISTER_COUNT(RC)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .read_register_index_1 (rd_idx_1),
    .read_register_index_2 (rd_idx_2),
    .read_data_1           (rd_data_1),
    .read_data_2           (rd_data_2),
    .write_register_index  (wr_idx),
    .write_data            (wr_data),
    .write_signal          (wr_sig),
    .clear_request         (clr_req),
    .clear_busy            (clr_busy),
    .clear_done            (clr_done),
    .write_rejected        (wr_rej),
    .rejected_write_count  (rej_cnt)
  );

  // Clock
  always #5 clock = ~clock;

  // Advance one cycle. Sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RC; i++) model[i] = DW'(i);
  endtask

  initial begin
    int busy_cycles;

    // Reset
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    rd_idx_1 = 5'd5;
    rd_idx_2 = 5'd31;
    #1;
    push(model[5]);  chk("reset_rd1_idx5", rd_data_1);
    push(model[31]); chk("reset_rd2_idx31", rd_data_2);
    push('0); chk("reset_wr_rej", DW'(wr_rej));
    push('0); chk("reset_rej_cnt", DW'(rej_cnt));
    push('0); chk("reset_busy", DW'(clr_busy));
    push('0); chk("reset_done", DW'(clr_done));

    // Accepted write to 7 and same-cycle read
    wr_sig = 1'b1; wr_idx = 5'd7; wr_data = 32'hDEADBEEF;
    rd_idx_1 = 5'd7; rd_idx_2 = 5'd0;
    #1;
`ifdef READ_BYPASS_EN
    push(32'hDEADBEEF);
`else
    push(model[7]);
`endif
    chk("same_cycle_rd7", rd_data_1);
    push('0); chk("rd_idx0_during_write", rd_data_2);
    model[7] = 32'hDEADBEEF;
    push(model[7]);   // read of index 7 expected after the edge
    push('0);         // accepted write produces no rejection
    tick();
    wr_sig = 1'b0;
    #1;
    chk("next_cycle_rd7", rd_data_1);
    chk("accepted_no_rej", DW'(wr_rej));

    // Rejected write to index 0
    wr_sig = 1'b1; wr_idx = 5'd0; wr_data = 32'h1234;
    rd_idx_1 = 5'd0;
    #1;
    push('0); chk("idx0_write_bypass_none", rd_data_1);
    push(1); push(1); push('0);
    tick();
    wr_sig = 1'b0;
    #1;
    chk("idx0_rej_pulse", DW'(wr_rej));
    chk("idx0_rej_cnt1", DW'(rej_cnt));
    chk("idx0_still0", rd_data_1);
    tick();
    push('0); chk("rej_pulse_one_cycle", DW'(wr_rej));
    push('0); chk("wr_sig0_no_event", DW'(wr_rej));

    // Clear sweep: mid-sweep write rejected, second request ignored
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= RC - 1; c++) begin
      push(1); chk($sformatf("sweep_busy_c%0d", c), DW'(clr_busy));
      push('0); chk($sformatf("sweep_no_done_c%0d", c), DW'(clr_done));
      if (c == 6) begin
        wr_sig = 1'b0;
        push(1); chk("sweep_wr9_rejected", DW'(wr_rej));
        push(2); chk("sweep_rej_cnt2", DW'(rej_cnt));
      end
      if (c == 5) begin
        wr_sig = 1'b1; wr_idx = 5'd9; wr_data = 32'h99;
      end
      if (c == 10) clr_req = 1'b1;
      if (c == 11) clr_req = 1'b0;
      if (c == 15) begin
        // Registers 1..14 are cleared by now; 20 is untouched.
        rd_idx_1 = 5'd3; rd_idx_2 = 5'd20;
        #1;
        push('0); chk("partial_rd3", rd_data_1);
        push(model[20]); chk("partial_rd20", rd_data_2);
      end
      tick();
    end
    push('0); chk("sweep_end_busy", DW'(clr_busy));
    push(1);  chk("sweep_end_done", DW'(clr_done));
    for (int i = 0; i < RC; i++) model[i] = '0;
    tick();
    push('0); chk("done_one_cycle", DW'(clr_done));
    push('0); chk("no_restart_busy", DW'(clr_busy));
    for (int i = 0; i < RC; i += 2) begin
      rd_idx_1 = IW'(i); rd_idx_2 = IW'(i + 1);
      #1;
      push(model[i]);     chk($sformatf("cleared_rd%0d", i), rd_data_1);
      push(model[i + 1]); chk($sformatf("cleared_rd%0d", i + 1), rd_data_2);
    end

    // Reset aborts a sweep at cycle 10
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    rd_idx_1 = 5'd20; rd_idx_2 = 5'd3;
    #1;
    push('0); chk("abort_busy", DW'(clr_busy));
    push('0); chk("abort_no_done", DW'(clr_done));
    push(model[20]); chk("abort_rd20", rd_data_1);
    push(model[3]);  chk("abort_rd3", rd_data_2);
    push('0); chk("abort_rej_cnt", DW'(rej_cnt));
    tick();
    push('0); chk("abort_no_done_later", DW'(clr_done));
    push('0); chk("abort_idle_later", DW'(clr_busy));

    // Accepted write and clear request in the same cycle
    wr_sig = 1'b1; wr_idx = 5'd4; wr_data = 32'hAA; clr_req = 1'b1;
    rd_idx_1 = 5'd4;
    model[4] = 32'hAA;
    push('0); push(1); push(model[4]);
    tick();
    wr_sig = 1'b0; clr_req = 1'b0;
    #1;
    chk("wr_clr_no_rej", DW'(wr_rej));
    chk("wr_clr_busy", DW'(clr_busy));
    chk("wr_clr_rd4_written", rd_data_1);
    busy_cycles = 0;
    while (clr_busy && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    for (int i = 0; i < RC; i++) model[i] = '0;
    push(RC - 1); chk("wr_clr_busy_len", DW'(busy_cycles));
    push(1); chk("wr_clr_done", DW'(clr_done));
    push(model[4]); chk("wr_clr_rd4_cleared", rd_data_1);
    push('0); chk("wr_clr_rej_cnt", DW'(rej_cnt));

    // Saturation of the rejection counter
    wr_sig = 1'b1; wr_idx = 5'd0; wr_data = DW'($urandom_range(1, 32'hFFFF));
    for (int n = 0; n < 300; n++) begin
      if (n == 254) begin
        push(254); chk("sat_cnt_254", DW'(rej_cnt));
      end
      tick();
    end
    wr_sig = 1'b0;
    push(255); chk("sat_cnt_255", DW'(rej_cnt));
    push(1);   chk("sat_last_pulse", DW'(wr_rej));
    tick();
    push('0);  chk("sat_pulse_end", DW'(wr_rej));
    push(255); chk("sat_cnt_hold", DW'(rej_cnt));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
